// File: rtl/bullet_scheduler.sv
// Schedules bullet-engine update windows in vertical blank, including wipe passes after restart/reset.
// Optional watchdog on window length: define BULLET_SCHED_WATCHDOG_EN.
module bullet_scheduler #(
    parameter int H_ACTIVE     = 1920,
    parameter int V_ACTIVE     = 1080,
    parameter int UPDATE_DIV   = 1,
    parameter int CALC_TIMEOUT = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] display_col,
    input  logic [10:0] display_row,
    input  logic        restart,
    input  logic        pause,
    input  logic        engine_done,
    output logic        calc,
    output logic        hardReset,
    output logic [15:0] frame_count,
    output logic        overrun,
    output logic [1:0]  sched_state
);

    typedef enum logic [1:0] {
        ST_DISPLAY = 2'd0,
        ST_CALC    = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    generate
        if (H_ACTIVE < 1 || H_ACTIVE > 4096 || V_ACTIVE < 1 || V_ACTIVE > 2047 ||
            UPDATE_DIV < 1 || UPDATE_DIV > 255 || CALC_TIMEOUT < 1 || CALC_TIMEOUT > 8192)
        begin : g_bad_params
            $error("bullet_scheduler: parameter out of range");
        end
    endgenerate

    localparam logic [7:0] DIV_LAST = 8'(UPDATE_DIV - 1);

    state_t      state_q, state_d;
    logic        calc_q, calc_d;
    logic        hard_q, hard_d;
    logic [15:0] fcount_q, fcount_d;
    logic [7:0]  div_q, div_d;
    logic        ovr_q, ovr_d;
    logic        clr_pend_q, clr_pend_d;
    logic [3:0]  gap_q, gap_d;

    logic frame_start;
    logic scan_origin;
    logic in_window;
    logic wd_expire;

    assign frame_start = (display_row == 11'(V_ACTIVE)) && (display_col == 12'd0);
    assign scan_origin = (display_row == 11'd0) && (display_col == 12'd0);
    assign in_window   = (state_q == ST_CALC) || (state_q == ST_CLEAR);

`ifdef BULLET_SCHED_WATCHDOG_EN
    logic [12:0] wd_q, wd_d;

    assign wd_expire = (wd_q == 13'(CALC_TIMEOUT - 1));

    always_comb begin
        wd_d = wd_q;
        if (!in_window) begin
            wd_d = 13'd0;
        end else begin
            wd_d = wd_q + 13'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q <= 13'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fcount_d   = fcount_q;
        div_d      = div_q;
        ovr_d      = ovr_q;
        clr_pend_d = clr_pend_q;
        gap_d      = gap_q;

        // Frame bookkeeping advances in every state, even when no window opens.
        if (frame_start) begin
            fcount_d = fcount_q + 16'd1;
            div_d    = (div_q >= DIV_LAST) ? 8'd0 : div_q + 8'd1;
        end

        case (state_q)
            ST_DISPLAY: begin
                if (frame_start) begin
                    if (clr_pend_q) begin
                        state_d = ST_CLEAR;
                    end else if (!pause && (div_q == 8'd0)) begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC, ST_CLEAR: begin
                if (engine_done) begin
                    state_d = ST_GAP;
                end else if (scan_origin || wd_expire) begin
                    state_d = ST_GAP;
                    ovr_d   = 1'b1;
                end
                if (state_d == ST_GAP) begin
                    gap_d = 4'd0;
                    if (state_q == ST_CLEAR) begin
                        clr_pend_d = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == 4'd15) begin
                    state_d = ST_DISPLAY;
                end
            end
        endcase

        // A restart landing on the same cycle as a wipe exit must still be honoured.
        if (restart) begin
            clr_pend_d = 1'b1;
        end

        calc_d = (state_d == ST_CALC) || (state_d == ST_CLEAR);
        hard_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_DISPLAY;
            calc_q     <= 1'b0;
            hard_q     <= 1'b0;
            fcount_q   <= 16'd0;
            div_q      <= 8'd0;
            ovr_q      <= 1'b0;
            clr_pend_q <= 1'b1;
            gap_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            calc_q     <= calc_d;
            hard_q     <= hard_d;
            fcount_q   <= fcount_d;
            div_q      <= div_d;
            ovr_q      <= ovr_d;
            clr_pend_q <= clr_pend_d;
            gap_q      <= gap_d;
        end
    end

    assign calc        = calc_q;
    assign hardReset   = hard_q;
    assign frame_count = fcount_q;
    assign overrun     = ovr_q;
    assign sched_state = state_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler on a 24x12 scan (16x8 active), UPDATE_DIV=2, CALC_TIMEOUT=40.
module tb_bullet_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] display_col;
    logic [10:0] display_row;
    logic        restart;
    logic        pause;
    logic        engine_done;
    logic        calc;
    logic        hardReset;
    logic [15:0] frame_count;
    logic        overrun;
    logic [1:0]  sched_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bullet_scheduler #(
        .H_ACTIVE(16),
        .V_ACTIVE(8),
        .UPDATE_DIV(2),
        .CALC_TIMEOUT(40)
    ) dut (
        .clock(clock),
        .reset(reset),
        .display_col(display_col),
        .display_row(display_row),
        .restart(restart),
        .pause(pause),
        .engine_done(engine_done),
        .calc(calc),
        .hardReset(hardReset),
        .frame_count(frame_count),
        .overrun(overrun),
        .sched_state(sched_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        pause;
        logic        rst_pulse;
        logic [1:0]  exp_state;
        logic        exp_hr;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (display_col == 12'd23) begin
            display_col = 12'd0;
            display_row = (display_row == 11'd11) ? 11'd0 : display_row + 11'd1;
        end else begin
            display_col = display_col + 12'd1;
        end
    endtask

    task automatic run_to(input int r, input int c);
        int n;
        n = 0;
        while (!(display_row == 11'(r) && display_col == 12'(c)) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            total_cnt++;
            $display("FAIL scan_reach: got row %0d col %0d expected row %0d col %0d",
                     display_row, display_col, r, c);
        end
    endtask

    task automatic wait_gap(output int n);
        n = 0;
        while (sched_state == 2'd3 && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int exp_len;
        logic exp_win;

        // frames 2..11: {pause, restart in window, state, hardReset, frame_count}
        vecs[0] = '{1'b0, 1'b0, 2'd0, 1'b0, 16'd2};
        vecs[1] = '{1'b0, 1'b0, 2'd1, 1'b0, 16'd3};
        vecs[2] = '{1'b0, 1'b0, 2'd0, 1'b0, 16'd4};
        vecs[3] = '{1'b0, 1'b0, 2'd1, 1'b0, 16'd5};
        vecs[4] = '{1'b0, 1'b0, 2'd0, 1'b0, 16'd6};
        vecs[5] = '{1'b0, 1'b1, 2'd1, 1'b0, 16'd7};
        vecs[6] = '{1'b1, 1'b0, 2'd2, 1'b1, 16'd8};
        vecs[7] = '{1'b1, 1'b0, 2'd0, 1'b0, 16'd9};
        vecs[8] = '{1'b0, 1'b0, 2'd0, 1'b0, 16'd10};
        vecs[9] = '{1'b0, 1'b0, 2'd1, 1'b0, 16'd11};

        reset       = 1'b1;
        display_col = 12'd0;
        display_row = 11'd0;
        restart     = 1'b0;
        pause       = 1'b0;
        engine_done = 1'b0;

        repeat (3) tick();
        check("rst_state", 32'(sched_state), 32'd0);
        check("rst_calc", 32'(calc), 32'd0);
        check("rst_hard", 32'(hardReset), 32'd0);
        check("rst_fcount", 32'(frame_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;

        // Frame 1: wipe pass after reset, engine finishes at cycle +10
        run_to(8, 0);
        check("f1_pre_calc", 32'(calc), 32'd0);
        tick();
        check("f1_state", 32'(sched_state), 32'd2);
        check("f1_calc", 32'(calc), 32'd1);
        check("f1_hard", 32'(hardReset), 32'd1);
        check("f1_fcount", 32'(frame_count), 32'd1);
        repeat (9) tick();
        check("f1_still_clear", 32'(sched_state), 32'd2);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        check("f1_gap_state", 32'(sched_state), 32'd3);
        check("f1_gap_calc", 32'(calc), 32'd0);
        check("f1_gap_hard", 32'(hardReset), 32'd0);
        wait_gap(n);
        check("f1_gap_len", 32'(n), 32'd16);
        check("f1_back_display", 32'(sched_state), 32'd0);

        for (int i = 0; i < 10; i++) begin
            pause = vecs[i].pause;
            exp_win = (vecs[i].exp_state == 2'd1) || (vecs[i].exp_state == 2'd2);
            run_to(8, 0);
            tick();
            check($sformatf("v%0d_state", i), 32'(sched_state), 32'(vecs[i].exp_state));
            check($sformatf("v%0d_calc", i), 32'(calc), 32'(exp_win));
            check($sformatf("v%0d_hard", i), 32'(hardReset), 32'(vecs[i].exp_hr));
            check($sformatf("v%0d_fcount", i), 32'(frame_count), 32'(vecs[i].exp_fc));
            if (exp_win) begin
                for (int c = 0; c < 4; c++) begin
                    restart = vecs[i].rst_pulse && (c == 1);
                    tick();
                    restart = 1'b0;
                end
                check($sformatf("v%0d_win_hold", i), 32'(sched_state), 32'(vecs[i].exp_state));
                check($sformatf("v%0d_win_hard", i), 32'(hardReset), 32'(vecs[i].exp_hr));
                engine_done = 1'b1;
                tick();
                engine_done = 1'b0;
                check($sformatf("v%0d_exit_gap", i), 32'(sched_state), 32'd3);
                wait_gap(n);
                check($sformatf("v%0d_gap_len", i), 32'(n), 32'd16);
            end
            pause = 1'b0;
        end
        check("no_overrun_yet", 32'(overrun), 32'd0);

        // Frame 12 skipped by divider, frame 13 window starved of engine_done
        run_to(8, 0);
        tick();
        check("f12_state", 32'(sched_state), 32'd0);
        run_to(8, 0);
        tick();
        check("f13_state", 32'(sched_state), 32'd1);
        check("f13_fcount", 32'(frame_count), 32'd13);
`ifdef BULLET_SCHED_WATCHDOG_EN
        exp_len = 40;
`else
        exp_len = 96;
`endif
        n = 0;
        while (sched_state == 2'd1 && n < 200) begin
            n++;
            tick();
        end
        check("starve_len", 32'(n), 32'(exp_len));
        check("starve_gap", 32'(sched_state), 32'd3);
        check("starve_overrun", 32'(overrun), 32'd1);
        wait_gap(n);
        repeat (20) tick();
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a wipe pass
        restart = 1'b1;
        tick();
        restart = 1'b0;
        run_to(8, 0);
        tick();
        check("f14_state", 32'(sched_state), 32'd2);
        check("f14_hard", 32'(hardReset), 32'd1);
        check("f14_fcount", 32'(frame_count), 32'd14);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_calc", 32'(calc), 32'd0);
        check("midrst_hard", 32'(hardReset), 32'd0);
        check("midrst_state", 32'(sched_state), 32'd0);
        check("midrst_fcount", 32'(frame_count), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        engine_done = 1'b1;
        run_to(8, 0);
        engine_done = 1'b0;
        check("quiet_calc", 32'(calc), 32'd0);
        check("quiet_state", 32'(sched_state), 32'd0);
        check("quiet_fcount", 32'(frame_count), 32'd0);
        tick();
        check("post_rst_state", 32'(sched_state), 32'd2);
        check("post_rst_hard", 32'(hardReset), 32'd1);
        check("post_rst_fcount", 32'(frame_count), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
